dbus_load_unit: RTL and testbench

Load-side data-bus engine for the 64-bit RV pipeline. It accepts one load request at a time from the memory stage and issues an aligned doubleword read on the data bus. It waits for the bus response, then extracts and sign- or zero-extends the addressed byte, half, word or doubleword. The result is the value the writeback stage selects as DBUS read data when the DBUS source is chosen for the register-file write port.

---
 rtl/dbus_load_unit.sv | 159 +++++++++++++++
 tb/tb_dbus_load_unit.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dbus_load_unit.sv
// Load-side data-bus engine: issues an aligned dword read per load, then
// extracts and sign/zero-extends the addressed byte/half/word/dword.
module dbus_load_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [63:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [4:0]  req_rd,
    output logic        dreq_valid,
    output logic [63:0] dreq_addr,
    output logic [1:0]  dreq_size,
    input  logic        dresp_addr_ok,
    input  logic        dresp_data_ok,
    input  logic [63:0] dresp_data,
    output logic        resp_valid,
    output logic [63:0] resp_data,
    output logic [4:0]  resp_rd,
    output logic        resp_misalign
);

    localparam int unsigned XLEN = 64;
    localparam int unsigned RD_W = 5;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE
    } state_e;

    state_e            state_q, state_d;
    logic [2:0]        offset_q;
    logic [1:0]        size_q;
    logic              unsigned_q;
    logic [RD_W-1:0]   rd_q;
    logic              req_ready_q;
    logic              dreq_valid_q;
    logic [XLEN-1:0]   dreq_addr_q;
    logic              resp_valid_q;
    logic [XLEN-1:0]   resp_data_q;
    logic [RD_W-1:0]   resp_rd_q;
    logic              resp_misalign_q;

    logic misalign_c;
    logic accept_c;
    logic capture_c;

    // Align the addressed element to bit 0, then extend to 64 bits.
    function automatic logic [XLEN-1:0] extract(input logic [XLEN-1:0] d,
                                                input logic [2:0]      off,
                                                input logic [1:0]      sz,
                                                input logic            uns);
        logic [XLEN-1:0] s;
        s = d >> {off, 3'b000};
        case (sz)
            2'd0:    return {{56{~uns & s[7]}},  s[7:0]};
            2'd1:    return {{48{~uns & s[15]}}, s[15:0]};
            2'd2:    return {{32{~uns & s[31]}}, s[31:0]};
            default: return s;
        endcase
    endfunction

    always_comb begin
        misalign_c = 1'b0;
        case (req_size)
            2'd1:    misalign_c = req_addr[0];
            2'd2:    misalign_c = |req_addr[1:0];
            2'd3:    misalign_c = |req_addr[2:0];
            default: misalign_c = 1'b0;
        endcase
    end

    assign accept_c  = req_valid && (state_q == S_IDLE);
    assign capture_c = ((state_q == S_REQ) && dresp_addr_ok && dresp_data_ok) ||
                       ((state_q == S_WAIT) && dresp_data_ok);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    state_d = misalign_c ? S_DONE : S_REQ;
                end
            end
            S_REQ: begin
                // data_ok without addr_ok is a bus protocol violation and is ignored.
                if (dresp_addr_ok) begin
                    state_d = dresp_data_ok ? S_DONE : S_WAIT;
                end
            end
            S_WAIT: begin
                if (dresp_data_ok) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Request latch and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            offset_q        <= 3'd0;
            size_q          <= 2'd0;
            unsigned_q      <= 1'b0;
            rd_q            <= '0;
            req_ready_q     <= 1'b1;
            dreq_valid_q    <= 1'b0;
            dreq_addr_q     <= '0;
            resp_valid_q    <= 1'b0;
            resp_data_q     <= '0;
            resp_rd_q       <= '0;
            resp_misalign_q <= 1'b0;
        end else begin
            req_ready_q  <= (state_d == S_IDLE);
            dreq_valid_q <= (state_d == S_REQ);
            resp_valid_q <= (state_d == S_DONE);
            if (accept_c) begin
                offset_q   <= req_addr[2:0];
                size_q     <= req_size;
                unsigned_q <= req_unsigned;
                rd_q       <= req_rd;
                if (misalign_c) begin
                    resp_data_q     <= '0;
                    resp_rd_q       <= req_rd;
                    resp_misalign_q <= 1'b1;
                end else begin
                    dreq_addr_q <= {req_addr[XLEN-1:3], 3'b000};
                end
            end else if (capture_c) begin
                resp_data_q     <= extract(dresp_data, offset_q, size_q, unsigned_q);
                resp_rd_q       <= rd_q;
                resp_misalign_q <= 1'b0;
            end
        end
    end

    assign req_ready     = req_ready_q;
    assign dreq_valid    = dreq_valid_q;
    assign dreq_addr     = dreq_addr_q;
    assign dreq_size     = 2'd3;
    assign resp_valid    = resp_valid_q;
    assign resp_data     = resp_data_q;
    assign resp_rd       = resp_rd_q;
    assign resp_misalign = resp_misalign_q;

endmodule

// File: tb/tb_dbus_load_unit.sv
// Directed bench for dbus_load_unit with a cycle-window timing model and a
// value model of load extraction.
module tb_dbus_load_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [63:0] req_addr = '0;
    logic [1:0]  req_size = '0;
    logic        req_unsigned = 1'b0;
    logic [4:0]  req_rd = '0;
    logic        dreq_valid;
    logic [63:0] dreq_addr;
    logic [1:0]  dreq_size;
    logic        dresp_addr_ok = 1'b0;
    logic        dresp_data_ok = 1'b0;
    logic [63:0] dresp_data = '0;
    logic        resp_valid;
    logic [63:0] resp_data;
    logic [4:0]  resp_rd;
    logic        resp_misalign;

    dbus_load_unit dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_addr      (req_addr),
        .req_size      (req_size),
        .req_unsigned  (req_unsigned),
        .req_rd        (req_rd),
        .dreq_valid    (dreq_valid),
        .dreq_addr     (dreq_addr),
        .dreq_size     (dreq_size),
        .dresp_addr_ok (dresp_addr_ok),
        .dresp_data_ok (dresp_data_ok),
        .dresp_data    (dresp_data),
        .resp_valid    (resp_valid),
        .resp_data     (resp_data),
        .resp_rd       (resp_rd),
        .resp_misalign (resp_misalign)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    // Model state: the current load's timing windows and its expected result.
    bit          m_active = 1'b0;
    int          m_acc = 0;
    int          m_dv_end = 0;
    int          m_resp = 0;
    bit          m_mis = 1'b0;
    logic [63:0] m_res = '0;
    logic [63:0] m_dreq_addr = '0;
    logic [4:0]  m_rd = '0;
    logic [63:0] held_data = '0;
    logic [4:0]  held_rd = '0;
    bit          held_mis = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%016h expected 0x%016h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [63:0] model_result(input logic [63:0] data, input logic [2:0] off,
                                                 input logic [1:0] size, input bit uns);
        int bits;
        logic [63:0] v;
        logic [63:0] mask;
        bits = 8 * (1 << size);
        v = data >> (8 * int'(off));
        if (bits < 64) begin
            mask = (64'd1 << bits) - 64'd1;
            v = v & mask;
            if (!uns && v[bits-1]) v = v | ~mask;
        end
        return v;
    endfunction

    function automatic bit model_misaligned(input logic [63:0] addr, input logic [1:0] size);
        logic [63:0] m;
        m = (64'd1 << size) - 64'd1;
        return (addr & m) != 64'd0;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        bit e_busy, e_dv, e_rv;
        e_busy = m_active && (cyc > m_acc) && (cyc <= m_resp);
        e_dv   = m_active && !m_mis && (cyc > m_acc) && (cyc <= m_dv_end);
        e_rv   = m_active && (cyc == m_resp);
        if (e_rv) begin
            held_data = m_res;
            held_rd   = m_rd;
            held_mis  = m_mis;
        end
        chk("req_ready", 64'(req_ready), 64'(!e_busy));
        chk("dreq_valid", 64'(dreq_valid), 64'(e_dv));
        if (e_dv) chk("dreq_addr", dreq_addr, m_dreq_addr);
        chk("dreq_size", 64'(dreq_size), 64'd3);
        chk("resp_valid", 64'(resp_valid), 64'(e_rv));
        chk("resp_data", resp_data, held_data);
        chk("resp_rd", 64'(resp_rd), 64'(held_rd));
        chk("resp_misalign", 64'(resp_misalign), 64'(held_mis));
    end

    // One load: present it, drive the bus with the given stall/delay, end the
    // cycle after the response so the next load can be accepted immediately.
    task automatic do_load(input string name, input logic [63:0] addr, input logic [1:0] size,
                           input bit uns, input logic [4:0] rd, input logic [63:0] data,
                           input int stall, input int delay, input bit keep_valid,
                           input logic [63:0] lit);
        req_addr     = addr;
        req_size     = size;
        req_unsigned = uns;
        req_rd       = rd;
        req_valid    = 1'b1;
        m_mis        = model_misaligned(addr, size);
        m_res        = m_mis ? 64'd0 : model_result(data, addr[2:0], size, uns);
        chk({name, " model"}, m_res, lit);
        m_acc        = cyc;
        m_dv_end     = cyc + 1 + stall;
        m_resp       = m_mis ? cyc + 1 : cyc + 2 + stall + delay;
        m_rd         = rd;
        m_dreq_addr  = addr & ~64'h7;
        m_active     = 1'b1;
        step();
        if (!keep_valid) req_valid = 1'b0;
        if (!m_mis) begin
            for (int i = 0; i < stall; i++) begin
                dresp_data_ok = 1'b1;
                dresp_data    = ~data;
                step();
            end
            dresp_addr_ok = 1'b1;
            dresp_data_ok = (delay == 0);
            dresp_data    = (delay == 0) ? data : ~data;
            step();
            dresp_addr_ok = 1'b0;
            dresp_data_ok = 1'b0;
            for (int j = 1; j <= delay; j++) begin
                if (j == delay) begin
                    dresp_data_ok = 1'b1;
                    dresp_data    = data;
                end
                step();
                dresp_data_ok = 1'b0;
            end
        end
        @(negedge clk);
        chk({name, " resp_data"}, resp_data, lit);
        chk({name, " resp_valid"}, 64'(resp_valid), 64'd1);
        step();
    endtask

    initial begin
        reset = 1'b0;
        repeat (3) step();
        @(negedge clk);
        chk("reset dreq_addr", dreq_addr, 64'd0);
        step();
        reset = 1'b1;
        repeat (2) step();

        do_load("dword", 64'h8000_0010, 2'd3, 1'b0, 5'd5, 64'h1122_3344_5566_7788, 0, 0, 1'b0,
                64'h1122_3344_5566_7788);
        step();
        do_load("lb off5", 64'h8000_000D, 2'd0, 1'b0, 5'd6, 64'h0000_F000_0000_0000, 0, 0, 1'b0,
                64'hFFFF_FFFF_FFFF_FFF0);
        do_load("lbu off5", 64'h8000_000D, 2'd0, 1'b1, 5'd7, 64'h0000_F000_0000_0000, 0, 0, 1'b0,
                64'h0000_0000_0000_00F0);
        step();
        do_load("lw delayed", 64'h8000_0104, 2'd2, 1'b0, 5'd8, 64'h8000_0001_DEAD_BEEF, 2, 3, 1'b0,
                64'hFFFF_FFFF_8000_0001);
        do_load("mis half", 64'h8000_0003, 2'd1, 1'b0, 5'd9, 64'h0, 0, 0, 1'b0, 64'h0);
        do_load("lh off6", 64'h8000_002E, 2'd1, 1'b0, 5'd10, 64'hABCD_0000_0000_0000, 1, 1, 1'b0,
                64'hFFFF_FFFF_FFFF_ABCD);
        do_load("lhu off6", 64'h8000_002E, 2'd1, 1'b1, 5'd11, 64'hABCD_0000_0000_0000, 0, 2, 1'b0,
                64'h0000_0000_0000_ABCD);
        do_load("lwu off0", 64'h8000_0030, 2'd2, 1'b1, 5'd12, 64'h1234_5678_9ABC_DEF0, 0, 0, 1'b0,
                64'h0000_0000_9ABC_DEF0);
        do_load("mis word", 64'h8000_0006, 2'd2, 1'b1, 5'd13, 64'h0, 0, 0, 1'b0, 64'h0);
        do_load("mis dword", 64'h8000_0004, 2'd3, 1'b0, 5'd14, 64'h0, 0, 0, 1'b0, 64'h0);
        do_load("ld unsigned", 64'h8000_0018, 2'd3, 1'b1, 5'd15, 64'hFEDC_BA98_7654_3210, 0, 2, 1'b0,
                64'hFEDC_BA98_7654_3210);
        do_load("lbu off7", 64'h8000_0007, 2'd0, 1'b1, 5'd16, 64'h8100_0000_0000_0000, 0, 0, 1'b0,
                64'h0000_0000_0000_0081);
        do_load("lb off7", 64'h8000_0007, 2'd0, 1'b0, 5'd17, 64'h8100_0000_0000_0000, 1, 0, 1'b0,
                64'hFFFF_FFFF_FFFF_FF81);
        step();

        // Back-to-back with req_valid held high across both loads.
        do_load("b2b first", 64'h8000_0044, 2'd2, 1'b0, 5'd20, 64'h7FFF_FFFF_0000_0000, 0, 0, 1'b1,
                64'h0000_0000_7FFF_FFFF);
        do_load("b2b second", 64'h8000_0042, 2'd1, 1'b0, 5'd21, 64'h0000_0000_8001_0000, 0, 1, 1'b0,
                64'hFFFF_FFFF_FFFF_8001);
        step();

        // Reset while waiting for read data; a late data_ok must be ignored.
        req_addr     = 64'h8000_0040;
        req_size     = 2'd3;
        req_unsigned = 1'b0;
        req_rd       = 5'd30;
        req_valid    = 1'b1;
        m_mis        = 1'b0;
        m_res        = 64'h0;
        m_rd         = 5'd30;
        m_dreq_addr  = 64'h8000_0040;
        m_acc        = cyc;
        m_dv_end     = cyc + 1;
        m_resp       = cyc + 1000;
        m_active     = 1'b1;
        step();
        req_valid     = 1'b0;
        dresp_addr_ok = 1'b1;
        step();
        dresp_addr_ok = 1'b0;
        reset     = 1'b0;
        m_active  = 1'b0;
        held_data = '0;
        held_rd   = '0;
        held_mis  = 1'b0;
        @(negedge clk);
        chk("mid-wait reset dreq_addr", dreq_addr, 64'd0);
        chk("mid-wait reset resp_rd", 64'(resp_rd), 64'd0);
        step();
        reset = 1'b1;
        step();
        dresp_data_ok = 1'b1;
        dresp_data    = 64'hCAFE_F00D_1234_5678;
        step();
        dresp_data_ok = 1'b0;
        repeat (3) step();

        do_load("after reset", 64'h8000_0000, 2'd0, 1'b0, 5'd3, 64'h0000_0000_0000_007F, 0, 0, 1'b0,
                64'h0000_0000_0000_007F);
        repeat (2) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
